// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the branch predictor.
package branch_predictor_pkg;

    localparam int BP_ENTRIES_DEFAULT = 32;

    typedef enum logic [1:0] {
        BP_STRONG_NT = 2'b00,
        BP_WEAK_NT   = 2'b01,
        BP_WEAK_T    = 2'b10,
        BP_STRONG_T  = 2'b11
    } BP_COUNTER_T;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state of a 2-bit saturating direction counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  BP_COUNTER_T count,
    input  logic        direction,
    output BP_COUNTER_T next_count
);

    // NOTE: default first so every path assigns next_count and no latch is inferred.
    always_comb begin
        next_count = count;
        if (direction) begin
            if (count != BP_STRONG_T) next_count = BP_COUNTER_T'(count + 2'd1);
        end else begin
            if (count != BP_STRONG_NT) next_count = BP_COUNTER_T'(count - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal BHT + tagged BTB predictor with zero-latency lookup.
// Define BP_FORWARD_EN to forward a same-cycle update into the lookup.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BP_ENTRIES = BP_ENTRIES_DEFAULT,
    parameter int XLEN       = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            fetch_EN,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    input  logic            update_EN,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_direction,
    input  logic [XLEN-1:0] update_target
);

    localparam int IDX_W = $clog2(BP_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    BP_COUNTER_T           counters   [BP_ENTRIES];
    logic [BP_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]      btb_tag    [BP_ENTRIES];
    logic [XLEN-1:0]       btb_target [BP_ENTRIES];

    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0] fetch_tag, upd_tag;
    BP_COUNTER_T      upd_next;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[XLEN-1:IDX_W+2];
    assign upd_idx   = update_pc[IDX_W+1:2];
    assign upd_tag   = update_pc[XLEN-1:IDX_W+2];

    // Byte offset within the word never affects prediction.
    logic unused_offset;
    assign unused_offset = &{1'b0, fetch_pc[1:0], update_pc[1:0]};

    bp_sat_counter u_upd_counter (
        .count      (counters[upd_idx]),
        .direction  (update_direction),
        .next_count (upd_next)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BP_ENTRIES; i++) counters[i] <= BP_WEAK_NT;
            btb_valid <= '0;
        end else if (update_EN) begin
            counters[upd_idx] <= upd_next;
            if (update_direction) btb_valid[upd_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target arrays are deliberately unreset; a clear valid bit masks them.
    always_ff @(posedge clock) begin
        if (update_EN && update_direction) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= update_target;
        end
    end

    BP_COUNTER_T      look_count;
    logic             look_valid;
    logic [TAG_W-1:0] look_tag;
    logic [XLEN-1:0]  look_target;
    logic             hit;

    always_comb begin
        look_count  = counters[fetch_idx];
        look_valid  = btb_valid[fetch_idx];
        look_tag    = btb_tag[fetch_idx];
        look_target = btb_target[fetch_idx];
`ifdef BP_FORWARD_EN
        // Forwarding is suppressed under reset so outputs stay quiet.
        if (update_EN && !reset && (upd_idx == fetch_idx)) begin
            look_count = upd_next;
            if (update_direction) begin
                look_valid  = 1'b1;
                look_tag    = upd_tag;
                look_target = update_target;
            end
        end
`else
`endif
        hit            = look_valid && (look_tag == fetch_tag);
        predict_taken  = fetch_EN && hit && look_count[1];
        predict_target = predict_taken ? look_target : fetch_pc + XLEN'(4);
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus queues expectations, a negedge monitor compares.
module tb_branch_predictor;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_A  = 32'h1000_0000;
    localparam logic [XLEN-1:0] PC_B  = 32'h2000_0000;
    localparam logic [XLEN-1:0] PC_C  = 32'h1000_0010;
    localparam logic [XLEN-1:0] PC_D  = 32'h1000_0008;
    localparam logic [XLEN-1:0] PC_W  = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] TGT_A = 32'h1000_0040;
    localparam logic [XLEN-1:0] TGT_2 = 32'h1000_0080;
    localparam logic [XLEN-1:0] TGT_C = 32'h3000_0000;

    logic            clock = 1'b0;
    logic            reset;
    logic            fetch_EN;
    logic [XLEN-1:0] fetch_pc;
    logic            predict_taken;
    logic [XLEN-1:0] predict_target;
    logic            update_EN;
    logic [XLEN-1:0] update_pc;
    logic            update_direction;
    logic [XLEN-1:0] update_target;

    branch_predictor #(.BP_ENTRIES(32), .XLEN(XLEN)) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_EN         (fetch_EN),
        .fetch_pc         (fetch_pc),
        .predict_taken    (predict_taken),
        .predict_target   (predict_target),
        .update_EN        (update_EN),
        .update_pc        (update_pc),
        .update_direction (update_direction),
        .update_target    (update_target)
    );

    always #5 clock = ~clock;

    logic [XLEN:0] exp_q [$];
    string         name_q [$];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [XLEN:0] act, input logic [XLEN:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got taken=%0b target=%h, expected taken=%0b target=%h",
                     name, act[XLEN], act[XLEN-1:0], exp[XLEN], exp[XLEN-1:0]);
        end
    endtask

    task automatic expect_out(input string name, input logic taken, input logic [XLEN-1:0] tgt);
        exp_q.push_back({taken, tgt});
        name_q.push_back(name);
    endtask

    task automatic drive(input logic fe, input logic [XLEN-1:0] fpc, input logic ue,
                         input logic [XLEN-1:0] upc, input logic udir, input logic [XLEN-1:0] utgt);
        fetch_EN         = fe;
        fetch_pc         = fpc;
        update_EN        = ue;
        update_pc        = upc;
        update_direction = udir;
        update_target    = utgt;
    endtask

    task automatic step(input logic fe, input logic [XLEN-1:0] fpc, input logic ue,
                        input logic [XLEN-1:0] upc, input logic udir, input logic [XLEN-1:0] utgt);
        @(posedge clock);
        #1;
        drive(fe, fpc, ue, upc, udir, utgt);
    endtask

    // Monitor: output is presented every cycle that has a queued expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                logic [XLEN:0] e;
                string         n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, {predict_taken, predict_target}, e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(1'b1, PC_A, 1'b0, '0, 1'b0, '0);
        expect_out("in_reset", 1'b0, PC_A + 4);
        @(negedge clock);
        #2 reset = 1'b0;

        step(1, PC_A, 0, '0, 0, '0);        expect_out("cold_start", 0, 32'h1000_0004);
        step(0, PC_A, 0, '0, 0, '0);        expect_out("fetch_off", 0, 32'h1000_0004);
        step(1, PC_W, 0, '0, 0, '0);        expect_out("wrap_pc4", 0, 32'h0000_0000);

        step(1, PC_A, 1, PC_A, 1, TGT_A);
`ifdef BP_FORWARD_EN
        expect_out("hazard_fwd", 1, TGT_A);
`else
        expect_out("hazard_nofwd", 0, PC_A + 4);
`endif
        step(1, PC_A, 0, '0, 0, '0);        expect_out("after_one_taken", 1, TGT_A);
        step(1, PC_D, 1, PC_A, 1, TGT_A);   expect_out("other_idx", 0, 32'h1000_000C);
        step(1, PC_A, 0, '0, 0, '0);        expect_out("trained", 1, TGT_A);
        step(1, PC_B, 0, '0, 0, '0);        expect_out("alias_tag_miss", 0, 32'h2000_0004);

        for (int i = 0; i < 3; i++) begin
            step(0, PC_A, 1, PC_A, 1, TGT_A); expect_out("train_fetch_off", 0, PC_A + 4);
        end
        // Not-taken via the aliasing PC: decrements the shared counter, BTB untouched.
        step(0, PC_W, 1, PC_B, 0, 32'hDEAD_BEEF); expect_out("nt_upd_wrap", 0, 32'h0000_0000);
        step(1, PC_A, 0, '0, 0, '0);        expect_out("sat_one_nt", 1, TGT_A);
        step(1, PC_W, 1, PC_A, 0, '0);      expect_out("invalid_entry", 0, 32'h0000_0000);
        step(1, PC_A, 0, '0, 0, '0);        expect_out("sat_two_nt", 0, PC_A + 4);

        step(0, PC_C, 1, PC_C, 1, TGT_C);   expect_out("train_c_off", 0, PC_C + 4);
        step(1, PC_C, 1, PC_A, 1, TGT_A);   expect_out("entry_c", 1, TGT_C);
        step(1, PC_A, 1, PC_A, 1, TGT_A);   expect_out("retrain_a", 1, TGT_A);
        step(1, PC_A, 0, '0, 0, '0);        expect_out("pre_reset", 1, TGT_A);

        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(1'b1, PC_A, 1'b0, '0, 1'b0, '0);
        expect_out("mid_reset", 0, PC_A + 4);
        @(negedge clock);
        #2 reset = 1'b0;

        step(1, PC_A, 0, '0, 0, '0);        expect_out("post_reset_a", 0, PC_A + 4);
        step(1, PC_C, 0, '0, 0, '0);        expect_out("post_reset_c", 0, PC_C + 4);
        step(0, PC_A, 1, PC_A, 1, TGT_2);   expect_out("post_reset_upd", 0, PC_A + 4);
        step(1, PC_A, 0, '0, 0, '0);        expect_out("counter_reset_01", 1, TGT_2);

        step(0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: BP_ENTRIES, default 32, number of BHT/BTB entries; power of two, 4..256.
REQ-002 Port: clock  input  1  single clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all predictor state.
REQ-004 Port: fetch_EN  input  1  lookup request from fetch this cycle.
REQ-005 Port: fetch_pc  input  XLEN  PC being fetched.
REQ-006 Port: predict_taken  output  1  predicted taken.
REQ-007 Port: predict_target  output  XLEN  predicted next PC.
REQ-008 Port: update_EN  input  1  resolved-branch update valid, driven by branch_stage.
REQ-009 Port: update_pc  input  XLEN  PC of the resolved branch.
REQ-010 Port: update_direction  input  1  actual outcome; 1 = taken.
REQ-011 Port: update_target  input  XLEN  actual target of a taken branch.

Function
REQ-012 Index = pc[log2(BP_ENTRIES)+1:2]; tag = pc[XLEN-1:log2(BP_ENTRIES)+2]; pc[1:0] ignored.
REQ-013 BHT: untagged array of 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-014 BTB: tagged array of {valid, tag, target}.
REQ-015 Lookup is combinational, zero latency: hit = valid[idx] and tag match.
REQ-016 predict_taken = fetch_EN and hit and counter[idx][1].
REQ-017 predict_target = BTB target when predict_taken; otherwise fetch_pc+4, wrapping modulo 2^XLEN.
REQ-018 When fetch_EN = 0: predict_taken = 0 and predict_target = fetch_pc+4.
REQ-019 On posedge with update_EN: counter[idx] increments if update_direction = 1, decrements if 0.
REQ-020 Counter saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.
REQ-021 On posedge with update_EN and update_direction = 1: BTB[idx] is written {1, tag, update_target}, replacing any previous entry.
REQ-022 Not-taken updates leave the BTB unchanged.
REQ-023 Lookup and update to the same index in the same cycle: lookup uses pre-update state unless BP_FORWARD_EN is defined (REQ-027).
REQ-024 Exactly one update per cycle; no internal buffering; updates are never dropped or stalled.

Reset
REQ-025 Reset asserted, at any time including mid-update: asynchronously, all counters = 01, all BTB valid = 0; tags and targets may be left unreset.
REQ-026 Outputs during and after reset: predict_taken = 0; predict_target = fetch_pc+4 until the first taken update.

Configuration
REQ-027 BP_FORWARD_EN defined: same-cycle update to the lookup index is forwarded, so the lookup sees the post-update counter and the post-update BTB entry.
REQ-028 BP_FORWARD_EN undefined: no forwarding; same-cycle update is visible from the next cycle.

Structure
REQ-029 Shared package holds BP_COUNTER_T (2-bit counter enum) and the BP_ENTRIES default constant; index/tag widths are derived locally.
REQ-030 One sub-module, bp_sat_counter: combinational next-state of a 2-bit counter given a direction.
REQ-031 Arrays are flops, not memory macros; target scale is 120-400 RTL lines.

Verification
REQ-032 Cold start: reset, then fetch_pc=0x1000_0000 -> predict_taken=0, predict_target=0x1000_0004.
REQ-033 Training: two taken updates at 0x1000_0000 with target 0x1000_0040 -> lookup at 0x1000_0000 gives predict_taken=1, target=0x1000_0040.
REQ-034 Saturation: five taken updates then one not-taken -> still taken; a second not-taken -> predict_taken=0.
REQ-035 Alias/tag miss: train 0x1000_0000, then look up 0x2000_0000 (same index, different tag) -> predict_taken=0, target=0x2000_0004.
REQ-036 Same-cycle hazard: counter=01, taken update and lookup at the same PC in one cycle -> predict_taken=0 without BP_FORWARD_EN, 1 with it.
REQ-037 Mid-run reset: train an entry, pulse reset between clock edges -> outputs drop immediately; next lookup predicts not-taken, PC+4.
